lfsr_gen: RTL and testbench
===========================

// Module: lfsr_gen
// PURPOSE
//  Parametrised Galois LFSR pseudo-random generator, successor to the fixed
//  26-bit x^26+x^8+x^7+x+1 generator. Width and polynomial are set by parameter.
//  Adds: free-run enable, counted burst mode with done pulse, zero-lock
//  recovery, and period-wrap detection against the last loaded seed.
//  Drives scramblers, BIST pattern sources and test stimulus in the datapath.
// PARAMETERS
//  WIDTH  26       state width in bits, >=3
//  POLY   'h183    feedback mask; bit i set = term x^i (x^WIDTH implied); bit0 must be 1
//  SEED   1        reset/default seed, nonzero, WIDTH bits
//  CW     16       burst length counter width
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous reset, active-high
//  en           in   1      free-run advance enable (IDLE only)
//  load         in   1      synchronous seed load, highest priority after rst
//  din          in   WIDTH  seed value for load
//  burst_start  in   1      start counted burst (IDLE only)
//  burst_len    in   CW     number of steps in burst, sampled at burst_start
//  q            out  WIDTH  LFSR state
//  out_bit      out  1      q[WIDTH-1], serial output
//  valid        out  1      high in cycle after q advanced (aligned with new q)
//  busy         out  1      high while in BURST
//  done         out  1      1-cycle pulse after last burst step
//  wrap         out  1      1-cycle pulse when q returns to seed_r
//  zero_fix     out  1      1-cycle pulse when a zero state/seed was replaced
// BEHAVIOUR
//  Reset (async, rst=1): q=SEED, seed_r=SEED, cnt=0, state=IDLE; valid, busy,
//   done, wrap, zero_fix = 0. Outputs q/out_bit are live immediately.
//  Step function: nxt = {q[WIDTH-2:0],1'b0} ^ (q[WIDTH-1] ? POLY : 0).
//  Priority per cycle: load > zero-lock > burst/en advance.
//  load=1: q <= (din!=0) ? din : SEED; seed_r <= same value; zero_fix=1 iff
//   din==0; state -> IDLE (aborts burst, no done); valid=0, wrap=0.
//  Zero-lock: if q==0 and no load, q <= SEED, zero_fix=1, no valid.
//  FSM states IDLE, BURST:
//   IDLE: en=1 -> q<=nxt, valid=1. burst_start=1 & burst_len!=0 -> cnt<=burst_len,
//    state->BURST, no step this cycle. burst_start wins over en.
//    burst_start with burst_len==0 -> done pulses next cycle, no step.
//   BURST: every cycle q<=nxt, valid=1, cnt<=cnt-1; en and burst_start ignored.
//    When cnt==1 at the step, state->IDLE and done=1 in the following cycle,
//    i.e. done coincides with the first IDLE cycle; busy=1 for exactly
//    burst_len cycles.
//  wrap: registered; =1 in the cycle q becomes seed_r through a step.
//   Not asserted on load.
//  valid, done, wrap, zero_fix are registered pulses, 0 when not set this cycle.
//  Latency: load or step visible on q one clock after the edge it is sampled on.
//  rst mid-burst: immediate return to reset state; no done.
//  Arithmetic: cnt unsigned CW bits; never decrements below 0.
// TESTING
//  T1 W=26,POLY='h183: load din=1 then en=1 -> q=2,4,8...;
//     q='h2000000 steps to q='h183, valid each cycle.
//  T2 W=4,POLY='h3,SEED=1: en held 15 cycles -> wrap pulses on 15th step,
//     q=1; sequence visits all 15 nonzero states.
//  T3 W=4: burst_start, len=3 from q=1 -> busy 3 cycles, q=2,4,8; done 1 cycle;
//     q holds 8 with en=0.
//  T4 load din=0 -> q=SEED, seed_r=SEED, zero_fix=1 for one cycle;
//     load din='h5 mid-burst -> q=5, busy=0, no done.
//  T5 assert rst asynchronously mid-burst, between edges -> q=SEED and all
//     flags 0 before the next edge; after release, IDLE with en=0 holds q.
//  T6 burst_start with len=0 -> no step, done one cycle later;
//     burst_start and en together -> burst taken, en ignored.

Source files
------------

// File: rtl/lfsr_gen.sv
// Parametrised Galois LFSR with free-run and counted-burst stepping, zero-lock
// recovery and period-wrap detection against the last loaded seed.
module lfsr_gen #(
  parameter int unsigned        WIDTH = 26,
  parameter logic [WIDTH-1:0]   POLY  = WIDTH'('h183),
  parameter logic [WIDTH-1:0]   SEED  = WIDTH'(1),
  parameter int unsigned        CW    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             burst_start,
  input  logic [CW-1:0]    burst_len,
  output logic [WIDTH-1:0] q,
  output logic             out_bit,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic             zero_fix
);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] seed_q;
  logic [CW-1:0]    cnt_q;
  logic             valid_q, done_q, wrap_q, zero_fix_q;
  logic [WIDTH-1:0] nxt;

  always_comb begin
    nxt = {lfsr_q[WIDTH-2:0], 1'b0} ^ (lfsr_q[WIDTH-1] ? POLY : '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      lfsr_q     <= SEED;
      seed_q     <= SEED;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      wrap_q     <= 1'b0;
      zero_fix_q <= 1'b0;
    end else begin
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      wrap_q     <= 1'b0;
      zero_fix_q <= 1'b0;
      if (load) begin
        // A zero seed would lock the register, so substitute the default.
        if (din != '0) begin
          lfsr_q <= din;
          seed_q <= din;
        end else begin
          lfsr_q     <= SEED;
          seed_q     <= SEED;
          zero_fix_q <= 1'b1;
        end
        state_q <= StIdle;
        cnt_q   <= '0;
      end else if (lfsr_q == '0) begin
        lfsr_q     <= SEED;
        zero_fix_q <= 1'b1;
      end else begin
        case (state_q)
          StIdle: begin
            if (burst_start) begin
              if (burst_len != '0) begin
                cnt_q   <= burst_len;
                state_q <= StBurst;
              end else begin
                done_q <= 1'b1;
              end
            end else if (en) begin
              lfsr_q  <= nxt;
              valid_q <= 1'b1;
              wrap_q  <= (nxt == seed_q);
            end
          end
          StBurst: begin
            lfsr_q  <= nxt;
            valid_q <= 1'b1;
            wrap_q  <= (nxt == seed_q);
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - CW'(1);
            end
            if (cnt_q <= CW'(1)) begin
              state_q <= StIdle;
              done_q  <= 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign q        = lfsr_q;
  assign out_bit  = lfsr_q[WIDTH-1];
  assign valid    = valid_q;
  assign busy     = (state_q == StBurst);
  assign done     = done_q;
  assign wrap     = wrap_q;
  assign zero_fix = zero_fix_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboard bench for lfsr_gen: a 4-bit instance for FSM/wrap behaviour and a
// 26-bit instance for the default polynomial.
module tb_lfsr_gen;

  typedef struct {
    int          cyc;
    logic [25:0] q;
    logic        flag;
  } ev_t;

  // Full x^4+x+1 cycle starting from 1.
  localparam logic [3:0] TBL [15] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
                                      4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic        en4, load4, bs4;
  logic [3:0]  din4, q4;
  logic [15:0] bl4;
  logic        ob4, valid4, busy4, done4, wrap4, zf4;

  logic        en26, load26;
  logic [25:0] din26, q26;
  logic        ob26, valid26, busy26, done26, wrap26, zf26;

  lfsr_gen #(.WIDTH(4), .POLY(4'h3), .SEED(4'h1), .CW(16)) u_dut4 (
    .clk(clk), .rst(rst), .en(en4), .load(load4), .din(din4),
    .burst_start(bs4), .burst_len(bl4), .q(q4), .out_bit(ob4), .valid(valid4),
    .busy(busy4), .done(done4), .wrap(wrap4), .zero_fix(zf4)
  );

  lfsr_gen #(.WIDTH(26), .POLY(26'h183), .SEED(26'h1), .CW(16)) u_dut26 (
    .clk(clk), .rst(rst), .en(en26), .load(load26), .din(din26),
    .burst_start(1'b0), .burst_len(16'd0), .q(q26), .out_bit(ob26), .valid(valid26),
    .busy(busy26), .done(done26), .wrap(wrap26), .zero_fix(zf26)
  );

  ev_t val4_q[$];
  ev_t done4_q[$];
  ev_t zf4_q[$];
  ev_t val26_q[$];

  int         idx4;
  logic [3:0] seed4;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_step4(input int at);
    ev_t e;
    idx4   = (idx4 + 1) % 15;
    e.cyc  = at;
    e.q    = {22'd0, TBL[idx4]};
    e.flag = (TBL[idx4] == seed4);
    val4_q.push_back(e);
  endtask

  task automatic push_done4(input int at);
    ev_t e;
    e.cyc = at; e.q = '0; e.flag = 1'b1;
    done4_q.push_back(e);
  endtask

  function automatic int find4(input logic [3:0] v);
    for (int i = 0; i < 15; i++) if (TBL[i] == v) return i;
    return 0;
  endfunction

  task automatic run_en4(input int n);
    int c;
    c   = cyc;
    en4 = 1'b1;
    for (int i = 0; i < n; i++) push_step4(c + 1 + i);
    repeat (n) tick();
    en4 = 1'b0;
  endtask

  task automatic burst4(input int len);
    int c;
    c   = cyc;
    bs4 = 1'b1;
    bl4 = 16'(len);
    for (int i = 0; i < len; i++) push_step4(c + 2 + i);
    push_done4(c + 1 + len);
    tick();
    bs4 = 1'b0;
  endtask

  always @(negedge clk) begin : mon4
    ev_t e;
    if (valid4) begin
      if (val4_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL valid4_unexpected: q=%0h at cycle %0d, expected no valid", q4, cyc);
      end else begin
        e = val4_q.pop_front();
        check("valid4_cycle", cyc, e.cyc);
        check("q4", {28'd0, q4}, {28'd0, e.q[3:0]});
        check("wrap4", {31'd0, wrap4}, {31'd0, e.flag});
      end
    end else if (wrap4) begin
      checks++; errors++;
      $display("FAIL wrap4_without_step: wrap=1 at cycle %0d, expected 0", cyc);
    end
    if (done4) begin
      if (done4_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL done4_unexpected: done=1 at cycle %0d, expected 0", cyc);
      end else begin
        e = done4_q.pop_front();
        check("done4_cycle", cyc, e.cyc);
      end
    end
    if (zf4) begin
      if (zf4_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL zf4_unexpected: zero_fix=1 at cycle %0d, expected 0", cyc);
      end else begin
        e = zf4_q.pop_front();
        check("zf4_cycle", cyc, e.cyc);
        check("zf4_q", {28'd0, q4}, {28'd0, e.q[3:0]});
      end
    end
  end

  always @(negedge clk) begin : mon26
    ev_t e;
    if (valid26) begin
      if (val26_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL valid26_unexpected: q=%0h at cycle %0d, expected no valid", q26, cyc);
      end else begin
        e = val26_q.pop_front();
        check("valid26_cycle", cyc, e.cyc);
        check("q26", {6'd0, q26}, {6'd0, e.q});
        check("out_bit26", {31'd0, ob26}, {31'd0, e.q[25]});
      end
    end
    if (busy26 || done26 || wrap26 || zf26) begin
      checks++; errors++;
      $display("FAIL flags26: busy/done/wrap/zf=%b%b%b%b at cycle %0d, expected 0000",
               busy26, done26, wrap26, zf26, cyc);
    end
  end

  initial begin
    int c;
    int nb;
    ev_t e;
    rst = 1'b1;
    en4 = 1'b0; load4 = 1'b0; bs4 = 1'b0; din4 = '0; bl4 = '0;
    en26 = 1'b0; load26 = 1'b0; din26 = '0;
    idx4 = 0; seed4 = 4'h1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_q4", {28'd0, q4}, 32'h1);
    check("rst_flags4", {26'd0, ob4, valid4, busy4, done4, wrap4, zf4}, 32'h0);
    check("rst_q26", {6'd0, q26}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;

    // T1: 26-bit walking one into the feedback term
    c = cyc;
    load26 = 1'b1; din26 = 26'h1;
    tick();
    load26 = 1'b0; en26 = 1'b1;
    for (int i = 0; i < 27; i++) begin
      e.cyc  = c + 2 + i;
      e.q    = (i < 25) ? (26'd1 << (i + 1)) : ((i == 25) ? 26'h183 : 26'h306);
      e.flag = 1'b0;
      val26_q.push_back(e);
    end
    repeat (27) tick();
    en26 = 1'b0;
    @(negedge clk);
    check("t1_hold26", {6'd0, q26}, 32'h306);

    // T2: full period from reset seed, wrap on the 15th step
    tick();
    run_en4(15);
    tick();
    @(negedge clk);
    check("t2_hold", {28'd0, q4}, 32'h1);

    // T3: burst of 3 from q=1
    tick();
    burst4(3);
    nb = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy4) nb++;
    end
    check("t3_busy_cycles", nb, 3);
    check("t3_hold", {28'd0, q4}, 32'h8);
    check("t3_out_bit", {31'd0, ob4}, 32'h1);

    // T6: zero-length burst, then burst_start together with en
    tick();
    burst4(0);
    tick();
    @(negedge clk);
    check("t6_len0_hold", {28'd0, q4}, 32'h8);
    check("t6_len0_busy", {31'd0, busy4}, 32'h0);
    tick();
    en4 = 1'b1;
    burst4(2);
    en4 = 1'b0;
    repeat (3) tick();

    // T4: zero load substitutes SEED; wrap then proves seed_r is SEED
    c = cyc;
    load4 = 1'b1; din4 = 4'h0;
    e.cyc = c + 1; e.q = 26'h1; e.flag = 1'b1;
    zf4_q.push_back(e);
    idx4 = 0; seed4 = 4'h1;
    tick();
    load4 = 1'b0;
    @(negedge clk);
    check("t4_zero_load_q", {28'd0, q4}, 32'h1);
    tick();
    run_en4(15);
    tick();

    // T4: load aborts a burst after two steps, no done
    c = cyc;
    bs4 = 1'b1; bl4 = 16'd5;
    push_step4(c + 2);
    push_step4(c + 3);
    tick();
    bs4 = 1'b0;
    tick();
    tick();
    load4 = 1'b1; din4 = 4'h5;
    tick();
    load4 = 1'b0;
    idx4 = find4(4'h5); seed4 = 4'h5;
    @(negedge clk);
    check("t4_abort_q", {28'd0, q4}, 32'h5);
    check("t4_abort_busy", {31'd0, busy4}, 32'h0);
    repeat (4) tick();
    run_en4(15);
    tick();

    // T5: asynchronous reset between edges mid-burst
    c = cyc;
    bs4 = 1'b1; bl4 = 16'd4;
    push_step4(c + 2);
    tick();
    bs4 = 1'b0;
    tick();
    @(negedge clk);
    #2;
    rst = 1'b1;
    val4_q.delete();
    done4_q.delete();
    #1;
    check("t5_rst_q4", {28'd0, q4}, 32'h1);
    check("t5_rst_flags4", {27'd0, valid4, busy4, done4, wrap4, zf4}, 32'h0);
    check("t5_rst_q26", {6'd0, q26}, 32'h1);
    #1;
    rst = 1'b0;
    idx4 = 0; seed4 = 4'h1;
    repeat (3) tick();
    @(negedge clk);
    check("t5_hold", {28'd0, q4}, 32'h1);
    check("t5_idle", {31'd0, busy4}, 32'h0);

    repeat (3) tick();
    check("sb_valid4_empty", val4_q.size(), 0);
    check("sb_done4_empty", done4_q.size(), 0);
    check("sb_zf4_empty", zf4_q.size(), 0);
    check("sb_valid26_empty", val26_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
